// File: rtl/rom_load_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : rom_load_ctl
//  Purpose  : Captures a cartridge ROM download into BRAM, mirror-pads it to a
//             power of two and holds the console core in reset until done.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_load_ctl #(
    parameter int MIN_SIZE = 2048,
    parameter int RST_HOLD = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic [16:0] rom_size,
    output logic [16:0] raw_size,
    output logic        core_reset,
    output logic        busy,
    output logic        overflow
);

    localparam logic [16:0] c_MIN_SIZE = 17'(MIN_SIZE);
    localparam logic [7:0]  c_RST_HOLD = 8'(RST_HOLD);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_FILL_RD = 3'd2,
        S_FILL_WR = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_dl_q;
    logic        w_dl_rise;
    logic        w_dl_fall;
    logic [7:0]  r_hold_cnt;
    logic [16:0] r_dst;
    logic [16:0] r_raw_size;
    logic [16:0] r_rom_size;
    logic        r_overflow;
    logic        r_we;
    logic [15:0] r_addr;
    logic [7:0]  r_din;
    logic [16:0] w_wr_end;
    logic [16:0] w_pad_size;
    logic [16:0] w_dst_inc;
    logic [15:0] w_src;

    // Smallest power of two >= raw, floored at MIN_SIZE; raw never exceeds 65536.
    function automatic logic [16:0] f_pad_size(input logic [16:0] raw);
        logic [16:0] p;
        p = 17'h10000;
        for (int i = 16; i >= 0; i--) begin
            if ((17'd1 << i) >= raw) begin
                p = 17'd1 << i;
            end
        end
        if (p < c_MIN_SIZE) begin
            p = c_MIN_SIZE;
        end
        return p;
    endfunction

    assign w_dl_rise  = ioctl_download & ~r_dl_q;
    assign w_dl_fall  = ~ioctl_download & r_dl_q;
    assign w_wr_end   = {1'b0, ioctl_addr[15:0]} + 17'd1;
    assign w_pad_size = f_pad_size(r_raw_size);
    assign w_dst_inc  = r_dst + 17'd1;
    // Fill only runs when raw_size < 65536, so 16 bits suffice for the source.
    assign w_src      = r_dst[15:0] - r_raw_size[15:0];

    assign rom_size   = r_rom_size;
    assign raw_size   = r_raw_size;
    assign overflow   = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        core_reset  = 1'b1;
        busy        = 1'b0;
        ram_we      = r_we;
        ram_addr    = r_addr;
        ram_din     = r_din;
        case (r_state)
            S_IDLE: begin
                core_reset = 1'b0;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (w_dl_fall) begin
                    if (r_raw_size == 17'd0 || r_raw_size == w_pad_size) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_FILL_RD;
                    end
                end
            end
            S_FILL_RD: begin
                busy        = 1'b1;
                ram_we      = 1'b0;
                ram_addr    = w_src;
                w_state_nxt = S_FILL_WR;
            end
            S_FILL_WR: begin
                // ram_dout holds the byte addressed during the preceding FILL_RD.
                busy     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = r_dst[15:0];
                ram_din  = ram_dout;
                if (w_dst_inc == r_rom_size) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_FILL_RD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == 8'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
        if (w_dl_rise) begin
            w_state_nxt = S_LOAD;
            core_reset  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dl_q     <= 1'b0;
            r_hold_cnt <= c_RST_HOLD;
            r_dst      <= 17'd0;
            r_raw_size <= 17'd0;
            r_rom_size <= 17'd0;
            r_overflow <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 16'd0;
            r_din      <= 8'd0;
        end else begin
            r_dl_q <= ioctl_download;
            r_we   <= 1'b0;

            // Counter sits at RST_HOLD outside HOLD, so every entry starts fresh.
            if (r_state == S_HOLD && r_hold_cnt != 8'd0) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end else begin
                r_hold_cnt <= c_RST_HOLD;
            end

            if (w_dl_rise) begin
                r_raw_size <= 17'd0;
                r_rom_size <= 17'd0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (ioctl_wr) begin
                            if (ioctl_addr[24:16] == 9'd0) begin
                                r_we   <= 1'b1;
                                r_addr <= ioctl_addr[15:0];
                                r_din  <= ioctl_dout;
                                if (w_wr_end > r_raw_size) begin
                                    r_raw_size <= w_wr_end;
                                end
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                        if (w_dl_fall) begin
                            r_rom_size <= (r_raw_size == 17'd0) ? 17'd0 : w_pad_size;
                            r_dst      <= r_raw_size;
                        end
                    end
                    S_FILL_WR: begin
                        r_dst <= w_dst_inc;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_load_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_load_ctl
//  Purpose  : Self-checking bench for rom_load_ctl with a BRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_load_ctl;

    localparam int MIN_SIZE = 2048;
    localparam int RST_HOLD = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [16:0] rom_size;
    logic [16:0] raw_size;
    logic        core_reset;
    logic        busy;
    logic        overflow;

    always #5 clk = ~clk;

    rom_load_ctl #(
        .MIN_SIZE (MIN_SIZE),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .rom_size       (rom_size),
        .raw_size       (raw_size),
        .core_reset     (core_reset),
        .busy           (busy),
        .overflow       (overflow)
    );

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        int          start;
        int          size;
        logic [16:0] exp_raw;
        logic [16:0] exp_rom;
        logic        exp_ovf;
        int          exp_fill;
        bit          mirror;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    vec_t        vecs [7];
    wr_t         sb [$];
    wr_t         sb_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          fill_cnt = 0;
    logic [16:0] cur_raw = 17'd1;
    logic [16:0] cur_rom = 17'd0;

    // Byte pattern that differs across 256-byte pages, so bad mirroring shows.
    function automatic logic [7:0] pat(input int a);
        logic [31:0] u;
        u = a;
        return u[7:0] ^ u[15:8] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ram_we) begin
            if (sb.size() > 0) begin
                sb_e = sb.pop_front();
                check("load_addr", int'(ram_addr), int'(sb_e.a));
                check("load_data", int'(ram_din), int'(sb_e.d));
            end else begin
                fill_cnt++;
                check("fill_range", int'(ram_addr >= cur_raw && ram_addr < cur_rom), 1);
                check("fill_data", int'(ram_din),
                      int'(pat((cur_raw != 17'd0) ? int'(ram_addr) % int'(cur_raw) : 0)));
            end
        end
    end

    task automatic start_dl();
        @(posedge clk);
        #1 ioctl_download = 1'b1;
    endtask

    task automatic write_bytes(input int start, input int size);
        for (int i = 0; i < size; i++) begin
            @(posedge clk);
            #1;
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(start + i);
            ioctl_dout = pat(start + i);
            if (start + i < 65536) begin
                sb.push_back('{16'(start + i), pat(start + i)});
            end
        end
    endtask

    task automatic end_dl();
        @(posedge clk);
        #1;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
    endtask

    // Counts cycles (from the current one) that core_reset stays high.
    task automatic wait_release(input string name, input int exp_n);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n <= exp_n + 64) begin
            @(negedge clk);
            if (!core_reset) done = 1'b1;
            else n++;
        end
        check(name, done ? n : -1, exp_n);
    endtask

    task automatic check_mirror(input int raw, input int rom);
        int bad = 0;
        for (int k = 0; k < rom; k++) begin
            if (mem[k] !== pat(k % raw)) bad++;
        end
        check("mirror_bad_bytes", bad, 0);
    endtask

    task automatic run_row(input vec_t v);
        cur_raw  = v.exp_raw;
        cur_rom  = v.exp_rom;
        fill_cnt = 0;
        start_dl();
        @(negedge clk);
        check("rise_core_reset", int'(core_reset), 1);
        write_bytes(v.start, v.size);
        end_dl();
        wait_release("release_cycles", RST_HOLD + 2 + 2 * v.exp_fill);
        check("raw_size", int'(raw_size), int'(v.exp_raw));
        check("rom_size", int'(rom_size), int'(v.exp_rom));
        check("overflow", int'(overflow), int'(v.exp_ovf));
        check("fill_writes", fill_cnt, v.exp_fill);
        check("sb_drained", sb.size(), 0);
        check("busy_idle", int'(busy), 0);
        if (v.mirror) check_mirror(int'(v.exp_raw), int'(v.exp_rom));
    endtask

    initial begin
        int wcnt;
        vecs[0] = '{0,     4096,  17'd4096,  17'd4096,  1'b0, 0,    1'b1};
        vecs[1] = '{0,     1024,  17'd1024,  17'd2048,  1'b0, 1024, 1'b1};
        // Tail of a 70000-byte image: crosses the 64 KB boundary.
        vecs[2] = '{60000, 10000, 17'd65536, 17'd65536, 1'b1, 0,    1'b0};
        vecs[3] = '{0,     6144,  17'd6144,  17'd8192,  1'b0, 2048, 1'b1};
        vecs[4] = '{0,     512,   17'd512,   17'd2048,  1'b0, 1536, 1'b1};
        vecs[5] = '{0,     1,     17'd1,     17'd2048,  1'b0, 2047, 1'b1};
        vecs[6] = '{0,     0,     17'd0,     17'd0,     1'b0, 0,    1'b0};

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        #23;
        check("rst_core_reset", int'(core_reset), 1);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_din", int'(ram_din), 0);
        check("rst_rom_size", int'(rom_size), 0);
        check("rst_raw_size", int'(raw_size), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_release("por_hold", RST_HOLD + 1);

        for (int r = 0; r < 7; r++) run_row(vecs[r]);

        // Asynchronous reset in the middle of a fill.
        cur_raw  = 17'd512;
        cur_rom  = 17'd2048;
        start_dl();
        write_bytes(0, 512);
        end_dl();
        repeat (100) @(negedge clk);
        check("midfill_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_ram_we", int'(ram_we), 0);
        check("arst_ram_addr", int'(ram_addr), 0);
        check("arst_ram_din", int'(ram_din), 0);
        check("arst_rom_size", int'(rom_size), 0);
        check("arst_raw_size", int'(raw_size), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_core_reset", int'(core_reset), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_release("arst_hold", RST_HOLD + 1);

        // New download rising in the middle of a fill.
        cur_raw  = 17'd1024;
        cur_rom  = 17'd2048;
        start_dl();
        write_bytes(0, 1024);
        end_dl();
        repeat (50) @(negedge clk);
        check("fill_busy", int'(busy), 1);
        @(posedge clk);
        #1 ioctl_download = 1'b1;
        @(negedge clk);
        check("abort_core_reset", int'(core_reset), 1);
        @(negedge clk);
        check("abort_raw_size", int'(raw_size), 0);
        check("abort_rom_size", int'(rom_size), 0);
        check("abort_busy", int'(busy), 1);
        cur_raw = 17'd300;
        cur_rom = 17'd2048;
        wcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ram_we) wcnt++;
        end
        check("abort_no_writes", wcnt, 0);
        fill_cnt = 0;
        write_bytes(0, 300);
        end_dl();
        wait_release("restart_release", RST_HOLD + 2 + 2 * 1748);
        check("restart_raw", int'(raw_size), 300);
        check("restart_rom", int'(rom_size), 2048);
        check("restart_fills", fill_cnt, 1748);
        check_mirror(300, 2048);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
